dmem_responder: RTL and testbench

//  Multi-cycle data-memory responder: the slave end of the CPU load/store port.

---
 rtl/dmem_responder_if.sv | 21 ++
 rtl/dmem_responder.sv | 114 +++++++++++
 tb/tb_dmem_responder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Load/store bus between the CPU memory stage and the data-memory responder.
interface dmem_responder_if;
   logic        req_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        ready_o;
   logic        ack_o;
   logic [31:0] rdata_o;
   logic        err_o;

   modport master (
      output req_i, we_i, addr_i, wdata_i,
      input  ready_o, ack_o, rdata_o, err_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wdata_i,
      output ready_o, ack_o, rdata_o, err_o
   );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with a LATENCY-cycle access time and a one-cycle ack.
// Optional DMEM_ERROR_EN: flags misaligned or out-of-range addresses on err_o.
module dmem_responder #(
   parameter int unsigned DEPTH   = 32,
   parameter int unsigned LATENCY = 3
) (
   input logic              clk_i,
   input logic              rst_i,
   dmem_responder_if.slave  bus
);
   localparam int unsigned ADDR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e              r_state, w_state_next;
   logic [3:0]          r_cnt, w_cnt_next;
   logic                r_we;
   logic [ADDR_W-1:0]   r_idx;
   logic [31:0]         r_wdata;
   logic                r_err_req;
   logic [31:0]         r_rdata;
   logic [31:0]         r_mem [DEPTH];

   logic                w_accept;
   logic                w_commit;
   logic                w_in_err;
   logic [ADDR_W-1:0]   w_in_idx;
   logic                w_op_we;
   logic                w_op_err;
   logic [ADDR_W-1:0]   w_op_idx;
   logic [31:0]         w_op_wdata;

   assign bus.ready_o = (r_state != StWait);
   assign bus.ack_o   = (r_state == StResp);
   assign bus.rdata_o = r_rdata;
   assign w_accept    = bus.req_i & bus.ready_o;
   assign w_in_idx    = bus.addr_i[ADDR_W+1:2];

`ifdef DMEM_ERROR_EN
   logic r_err;
   assign w_in_err  = (bus.addr_i[1:0] != 2'b00) || ((bus.addr_i >> (ADDR_W + 2)) != 32'd0);
   assign bus.err_o = r_err;
`else
   assign w_in_err  = 1'b0;
   assign bus.err_o = 1'b0;
`endif

   // With LATENCY = 1 the accept edge is also the commit edge, so use the live inputs.
   assign w_op_we    = w_accept ? bus.we_i    : r_we;
   assign w_op_idx   = w_accept ? w_in_idx    : r_idx;
   assign w_op_wdata = w_accept ? bus.wdata_i : r_wdata;
   assign w_op_err   = w_accept ? w_in_err    : r_err_req;
   assign w_commit   = rst_i && (w_state_next == StResp);

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      unique case (r_state)
         StIdle, StResp: begin
            if (w_accept) begin
               if (LATENCY == 1) begin
                  w_state_next = StResp;
               end else begin
                  w_state_next = StWait;
                  w_cnt_next   = 4'(LATENCY - 1);
               end
            end else begin
               w_state_next = StIdle;
            end
         end
         StWait: begin
            w_cnt_next = r_cnt - 4'd1;
            if (r_cnt == 4'd1) w_state_next = StResp;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state   <= StIdle;
         r_cnt     <= 4'd0;
         r_we      <= 1'b0;
         r_idx     <= '0;
         r_wdata   <= 32'd0;
         r_err_req <= 1'b0;
         r_rdata   <= 32'd0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         if (w_accept) begin
            r_we      <= bus.we_i;
            r_idx     <= w_in_idx;
            r_wdata   <= bus.wdata_i;
            r_err_req <= w_in_err;
         end
         if (w_commit) begin
            r_rdata <= (!w_op_we && !w_op_err) ? r_mem[w_op_idx] : 32'd0;
         end
      end
   end

`ifdef DMEM_ERROR_EN
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)        r_err <= 1'b0;
      else if (w_commit) r_err <= w_op_err;
   end
`endif

   // Array is deliberately not reset; commit is gated by rst_i so an aborted store never lands.
   always_ff @(posedge clk_i) begin
      if (w_commit && w_op_we && !w_op_err) r_mem[w_op_idx] <= w_op_wdata;
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY 3 by default, 1 with DMEM_ERROR_EN).
module tb_dmem_responder;
`ifdef DMEM_ERROR_EN
   localparam int unsigned Lat = 1;
`else
   localparam int unsigned Lat = 3;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder_if bus ();

   dmem_responder #(
      .DEPTH   (32),
      .LATENCY (Lat)
   ) u_dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called #1 after the accept edge; counts edges from accept (inclusive) until ack is seen.
   task automatic wait_ack(output int lat);
      lat = 1;
      while (bus.ack_o !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (bus.ack_o !== 1'b1) check("ack_timeout", {31'd0, bus.ack_o}, 32'd1);
   endtask

   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
      bus.req_i   = 1'b1;
      bus.we_i    = we;
      bus.addr_i  = addr;
      bus.wdata_i = wdata;
      @(posedge clk);
      #1;
      bus.req_i   = 1'b0;
      bus.we_i    = ~we;
      bus.addr_i  = 32'hFFFF_FFFC;
      bus.wdata_i = 32'hBAD0_BAD0;
      wait_ack(lat);
      rdata = bus.rdata_o;
      err   = bus.err_o;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          c1, c2;
      int          extra;

      bus.req_i   = 1'b0;
      bus.we_i    = 1'b0;
      bus.addr_i  = 32'd0;
      bus.wdata_i = 32'd0;
      rst_n       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, bus.ready_o}, 32'd1);
      check("rst_ack",   {31'd0, bus.ack_o},   32'd0);
      check("rst_rdata", bus.rdata_o,          32'd0);
      check("rst_err",   {31'd0, bus.err_o},   32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_ready", {31'd0, bus.ready_o}, 32'd1);
      check("post_rst_ack",   {31'd0, bus.ack_o},   32'd0);

      // Store then load the same word
      access(1'b1, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
      check("t1_st_lat",   32'(lat), Lat);
      check("t1_st_rdata", rd, 32'd0);
      access(1'b0, 32'h10, 32'd0, rd, er, lat);
      check("t1_ld_lat",   32'(lat), Lat);
      check("t1_ld_rdata", rd, 32'hDEAD_BEEF);
      check("t1_ld_err",   {31'd0, er}, 32'd0);
      @(posedge clk);
      #1;
      check("t1_ack_pulse", {31'd0, bus.ack_o},   32'd0);
      check("t1_ready_idle", {31'd0, bus.ready_o}, 32'd1);

      // Back-to-back loads with req held high
      access(1'b1, 32'h0, 32'h0102_0304, rd, er, lat);
      access(1'b1, 32'h4, 32'h0A0B_0C0D, rd, er, lat);
      @(posedge clk);
      #1;
      bus.req_i  = 1'b1;
      bus.we_i   = 1'b0;
      bus.addr_i = 32'h0;
      @(posedge clk);
      #1;
      bus.addr_i = 32'h4;
      wait_ack(lat);
      c1 = cyc;
      check("t2_lat0",   32'(lat), Lat);
      check("t2_rdata0", bus.rdata_o, 32'h0102_0304);
      @(posedge clk);
      #1;
      bus.req_i = 1'b0;
      wait_ack(lat);
      c2 = cyc;
      check("t2_rdata1",  bus.rdata_o, 32'h0A0B_0C0D);
      check("t2_spacing", 32'(c2 - c1), Lat);
      @(posedge clk);
      #1;

`ifndef DMEM_ERROR_EN
      // req pulsed during WAIT is ignored
      bus.req_i  = 1'b1;
      bus.we_i   = 1'b0;
      bus.addr_i = 32'h10;
      @(posedge clk);
      #1;
      check("t3_ready_wait0", {31'd0, bus.ready_o}, 32'd0);
      bus.addr_i = 32'h4;
      @(posedge clk);
      #1;
      check("t3_ready_wait1", {31'd0, bus.ready_o}, 32'd0);
      check("t3_ack_early",   {31'd0, bus.ack_o},   32'd0);
      bus.req_i = 1'b0;
      @(posedge clk);
      #1;
      check("t3_ack",   {31'd0, bus.ack_o}, 32'd1);
      check("t3_rdata", bus.rdata_o, 32'hDEAD_BEEF);
      extra = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (bus.ack_o === 1'b1) extra++;
      end
      check("t3_extra_ack", 32'(extra), 32'd0);

      // Reset mid-store aborts the write
      access(1'b1, 32'h20, 32'h1111_1111, rd, er, lat);
      check("t4_st_lat", 32'(lat), Lat);
      bus.req_i   = 1'b1;
      bus.we_i    = 1'b1;
      bus.addr_i  = 32'h20;
      bus.wdata_i = 32'h1234_5678;
      @(posedge clk);
      #1;
      bus.req_i = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("t4_rst_ack",   {31'd0, bus.ack_o},   32'd0);
      check("t4_rst_ready", {31'd0, bus.ready_o}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
      check("t4_rst_ack2",  {31'd0, bus.ack_o}, 32'd0);
      check("t4_rst_rdata", bus.rdata_o, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      access(1'b0, 32'h20, 32'd0, rd, er, lat);
      check("t4_ld_rdata", rd, 32'h1111_1111);

      // Upper address bits alias modulo DEPTH
      access(1'b1, 32'h80, 32'hA5A5_A5A5, rd, er, lat);
      check("t5_st_err", {31'd0, er}, 32'd0);
      access(1'b0, 32'h0, 32'd0, rd, er, lat);
      check("t5_ld_rdata", rd, 32'hA5A5_A5A5);
      check("t5_ld_err",   {31'd0, er}, 32'd0);
`else
      // Error reporting with LATENCY = 1
      access(1'b1, 32'h0, 32'h5A5A_5A5A, rd, er, lat);
      check("t6_pre_err", {31'd0, er}, 32'd0);
      access(1'b1, 32'h80, 32'hFFFF_FFFF, rd, er, lat);
      check("t6_st_lat",   32'(lat), 32'd1);
      check("t6_st_err",   {31'd0, er}, 32'd1);
      check("t6_st_rdata", rd, 32'd0);
      access(1'b0, 32'h13, 32'd0, rd, er, lat);
      check("t6_ld_err",   {31'd0, er}, 32'd1);
      check("t6_ld_rdata", rd, 32'd0);
      access(1'b0, 32'h0, 32'd0, rd, er, lat);
      check("t6_w0_rdata", rd, 32'h5A5A_5A5A);
      check("t6_w0_err",   {31'd0, er}, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
